// File: rtl/our_arb_pkg.sv
// rtl/our_arb_pkg.sv - shared types, defaults and helpers for the round-robin arbiter
package our_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN  = 2'd1,
        GAP  = 2'd2
    } arb_state_e;

    localparam int DEF_NUM_REQ        = 4;
    localparam int DEF_TIMEOUT_CYCLES = 16;

    // Index width for n requesters; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/our_rr_pick.sv
// rtl/our_rr_pick.sv - combinational round-robin picker searching upward from ptr with wrap
import our_arb_pkg::*;

module our_rr_pick #(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int IW      = idx_width(DEF_NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      ptr,
    output logic [NUM_REQ-1:0] pick,
    output logic [IW-1:0]      pick_id,
    output logic               any
);

    logic [IW:0]   sum;
    logic [IW-1:0] idx;

    // Walk candidates ptr, ptr+1, ... wrapping at NUM_REQ; the first requester seen wins.
    always_comb begin
        pick    = '0;
        pick_id = '0;
        any     = 1'b0;
        sum     = '0;
        idx     = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            sum = {1'b0, ptr} + (IW+1)'(i);
            if (sum >= (IW+1)'(NUM_REQ)) begin
                sum = sum - (IW+1)'(NUM_REQ);
            end
            idx = sum[IW-1:0];
            if (!any && req[idx]) begin
                any       = 1'b1;
                pick[idx] = 1'b1;
                pick_id   = idx;
            end
        end
    end

endmodule

// File: rtl/our_arbiter.sv
// rtl/our_arbiter.sv - round-robin arbiter with turnaround gap; OUR_ARB_TIMEOUT_EN adds forced release
import our_arb_pkg::*;

module our_arbiter #(
    parameter int NUM_REQ        = DEF_NUM_REQ,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req,
    input  logic                          done,
    output logic [NUM_REQ-1:0]            gnt,
    output logic [idx_width(NUM_REQ)-1:0] gnt_id,
    output logic                          start,
    output logic                          busy,
    output logic                          timeout_err
);

    localparam int IW = idx_width(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 16) begin : g_bad_num_req
        $error("our_arbiter: NUM_REQ must be in 2..16");
    end
    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("our_arbiter: TIMEOUT_CYCLES must be at least 2");
    end

    arb_state_e         state_q;
    logic [IW-1:0]      ptr_q;
    logic [NUM_REQ-1:0] gnt_q;
    logic [IW-1:0]      gnt_id_q;
    logic               start_q;
    logic               busy_q;
    logic               timeout_err_q;

    logic [NUM_REQ-1:0] pick;
    logic [IW-1:0]      pick_id;
    logic               any;

    logic [IW-1:0]      ptr_d;
    logic               release_d;
    logic               timeout_d;

    our_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IW      (IW)
    ) u_pick (
        .req     (req),
        .ptr     (ptr_q),
        .pick    (pick),
        .pick_id (pick_id),
        .any     (any)
    );

`ifdef OUR_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] own_cnt_q;

    // Force release on the last allowed OWN cycle unless a normal release is already happening.
    always_comb begin
        timeout_d = (own_cnt_q == CW'(TIMEOUT_CYCLES - 1)) && !release_d;
    end
`else
    // Ownership is unbounded in this build.
    always_comb begin
        timeout_d = 1'b0;
    end
`endif

    // Normal release conditions and the pointer value that follows the current owner.
    always_comb begin
        release_d = done || !req[gnt_id_q];
        if (gnt_id_q == IW'(NUM_REQ - 1)) begin
            ptr_d = '0;
        end else begin
            ptr_d = gnt_id_q + IW'(1);
        end
    end

    // Arbiter FSM; every output comes straight from a register updated here.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            ptr_q         <= '0;
            gnt_q         <= '0;
            gnt_id_q      <= '0;
            start_q       <= 1'b0;
            busy_q        <= 1'b0;
            timeout_err_q <= 1'b0;
`ifdef OUR_ARB_TIMEOUT_EN
            own_cnt_q     <= '0;
`endif
        end else begin
            start_q       <= 1'b0;
            timeout_err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (any) begin
                        gnt_q    <= pick;
                        gnt_id_q <= pick_id;
                        start_q  <= 1'b1;
                        busy_q   <= 1'b1;
                        state_q  <= OWN;
`ifdef OUR_ARB_TIMEOUT_EN
                        own_cnt_q <= '0;
`endif
                    end
                end
                OWN: begin
                    if (release_d || timeout_d) begin
                        gnt_q         <= '0;
                        gnt_id_q      <= '0;
                        busy_q        <= 1'b0;
                        ptr_q         <= ptr_d;
                        timeout_err_q <= timeout_d;
                        state_q       <= GAP;
                    end else begin
`ifdef OUR_ARB_TIMEOUT_EN
                        own_cnt_q <= own_cnt_q + CW'(1);
`endif
                    end
                end
                GAP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign gnt         = gnt_q;
    assign gnt_id      = gnt_id_q;
    assign start       = start_q;
    assign busy        = busy_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_our_arbiter.sv
// tb/tb_our_arbiter.sv - directed and randomized bench for our_arbiter with a behavioural model
module tb_our_arbiter;

    localparam int N  = 4;
    localparam int TO = 16;
`ifdef OUR_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         done = 1'b0;
    logic [N-1:0] req = 4'b1111;
    logic [N-1:0] gnt;
    logic [1:0]   gnt_id;
    logic         start;
    logic         busy;
    logic         timeout_err;

    int n_checks = 0;
    int n_errors = 0;

    our_arbiter #(
        .NUM_REQ        (N),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .done        (done),
        .gnt         (gnt),
        .gnt_id      (gnt_id),
        .start       (start),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Behavioural model: who owns the resource, whether we sit in the turnaround
    // cycle, where the search starts, and how long the owner has held it.
    int           m_own = -1;
    bit           m_gap = 1'b0;
    int           m_ptr = 0;
    int           m_age = 0;
    bit           e_start = 1'b0;
    bit           e_to = 1'b0;
    int           wait_cnt [N];
    logic [N-1:0] s_req;
    logic         s_done;
    logic         s_rst;
    logic [N-1:0] e_gnt;
    bit           rel;
    bit           tmo;
    int           cand;

    always @(posedge clk) begin
        s_req   = req;
        s_done  = done;
        s_rst   = rst;
        e_start = 1'b0;
        e_to    = 1'b0;
        if (s_rst) begin
            m_own = -1;
            m_gap = 1'b0;
            m_ptr = 0;
            m_age = 0;
            for (int i = 0; i < N; i++) wait_cnt[i] = 0;
        end else if (m_own >= 0) begin
            m_age = m_age + 1;
            rel = s_done || !s_req[m_own];
            tmo = TO_EN && !rel && (m_age == TO);
            if (rel || tmo) begin
                m_ptr = (m_own + 1) % N;
                m_own = -1;
                m_gap = 1'b1;
                e_to  = tmo;
            end
        end else if (m_gap) begin
            m_gap = 1'b0;
        end else if (s_req != '0) begin
            cand = -1;
            for (int k = 0; k < N; k++) begin
                if (cand < 0 && s_req[(m_ptr + k) % N]) cand = (m_ptr + k) % N;
            end
            m_own   = cand;
            m_age   = 0;
            e_start = 1'b1;
            for (int i = 0; i < N; i++) begin
                if (i == cand) begin
                    wait_cnt[i] = 0;
                end else if (s_req[i]) begin
                    wait_cnt[i] = wait_cnt[i] + 1;
                    check("fairness_wait", 32'(wait_cnt[i] <= N - 1), 32'd1);
                end
            end
        end
        if (!s_rst) begin
            for (int i = 0; i < N; i++) if (!s_req[i]) wait_cnt[i] = 0;
        end
        e_gnt = '0;
        if (m_own >= 0) e_gnt[m_own] = 1'b1;
        #1;
        check("model_gnt", 32'(gnt), 32'(e_gnt));
        check("model_gnt_id", 32'(gnt_id), 32'((m_own >= 0) ? m_own : 0));
        check("model_start", 32'(start), 32'(e_start));
        check("model_busy", 32'(busy), 32'(m_own >= 0));
        check("model_timeout_err", 32'(timeout_err), 32'(e_to));
    end

    int rot_exp [5] = '{0, 1, 2, 3, 0};

    initial begin
        // Reset held for two edges with every requester asking.
        tick();
        tick();
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_gnt_id", 32'(gnt_id), 32'd0);
        check("rst_start", 32'(start), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_timeout_err", 32'(timeout_err), 32'd0);
        rst = 1'b0;
        tick();
        check("first_gnt", 32'(gnt), 32'h1);
        check("first_start", 32'(start), 32'd1);

        // Rotation with done two cycles after every grant.
        for (int k = 0; k < 5; k++) begin
            check("rot_gnt_id", 32'(gnt_id), 32'(rot_exp[k]));
            check("rot_start", 32'(start), 32'd1);
            tick();
            check("rot_start_low", 32'(start), 32'd0);
            done = 1'b1;
            tick();
            done = 1'b0;
            check("rot_release_gnt", 32'(gnt), 32'd0);
            check("rot_release_busy", 32'(busy), 32'd0);
            if (k == 4) req = '0;
            tick();
            check("rot_gap_gnt", 32'(gnt), 32'd0);
            tick();
        end

        // Wrap and skip: serve 2 so ptr becomes 3, then only 0 and 2 request.
        req = 4'b0100;
        tick();
        check("ws_serve2", 32'(gnt_id), 32'd2);
        done = 1'b1;
        tick();
        done = 1'b0;
        req = 4'b0101;
        tick();
        tick();
        check("wrap_to_0", 32'(gnt), 32'h1);
        done = 1'b1;
        tick();
        done = 1'b0;
        tick();
        tick();
        check("skip_to_2", 32'(gnt), 32'h4);

        // Abandon: requester 1 owns and then drops its request.
        done = 1'b1;
        tick();
        done = 1'b0;
        req = 4'b0010;
        tick();
        tick();
        check("ab_owner", 32'(gnt), 32'h2);
        tick();
        req = 4'b0000;
        tick();
        check("ab_gnt_cleared", 32'(gnt), 32'd0);
        check("ab_no_timeout", 32'(timeout_err), 32'd0);
        req = 4'b1111;
        tick();
        tick();
        check("ab_ptr_is_2", 32'(gnt_id), 32'd2);

        // Reset during the third OWN cycle of requester 2.
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mr_gnt", 32'(gnt), 32'd0);
        check("mr_busy", 32'(busy), 32'd0);
        check("mr_timeout_err", 32'(timeout_err), 32'd0);
        tick();
        check("mr_next_owner", 32'(gnt), 32'h1);

`ifdef OUR_ARB_TIMEOUT_EN
        // Owner 0 never sees done: forced release after the 16th OWN cycle.
        for (int c = 0; c < TO - 1; c++) begin
            tick();
            check("to_hold_busy", 32'(busy), 32'd1);
        end
        tick();
        check("to_gnt_cleared", 32'(gnt), 32'd0);
        check("to_err_pulse", 32'(timeout_err), 32'd1);
        tick();
        check("to_err_single", 32'(timeout_err), 32'd0);
        tick();
        check("to_next_owner", 32'(gnt_id), 32'd1);
        // done on the 16th cycle wins over the timeout.
        for (int c = 0; c < TO - 1; c++) tick();
        done = 1'b1;
        tick();
        done = 1'b0;
        check("to_done_gnt", 32'(gnt), 32'd0);
        check("to_done_no_err", 32'(timeout_err), 32'd0);
        tick();
        tick();
`endif

        // Randomized traffic checked cycle by cycle against the model.
        for (int c = 0; c < 3000; c++) begin
            tick();
            rst  = ($urandom_range(0, 399) == 0);
            done = (m_own >= 0 && $urandom_range(0, 3) == 0) || ($urandom_range(0, 15) == 0);
            for (int i = 0; i < N; i++) begin
                if (m_own == i) begin
                    if ($urandom_range(0, 9) == 0) req[i] = 1'b0;
                end else if (!req[i]) begin
                    if ($urandom_range(0, 2) == 0) req[i] = 1'b1;
                end else begin
                    if ($urandom_range(0, 7) == 0) req[i] = 1'b0;
                end
            end
        end
        rst  = 1'b0;
        done = 1'b0;
        req  = '0;
        tick();
        tick();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/our_arbiter.md
# our_arbiter

Round-robin arbiter that shares one downstream resource (a single-port datapath driven through `our_interface`) between `NUM_REQ` requesters. It grants ownership to one requester at a time and holds the grant until the resource signals completion. It then rotates priority and inserts a one-cycle turnaround gap. The block sits between the requester agents and the shared resource, and is the DUT the UVM environment drives and monitors.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..16.
- `TIMEOUT_CYCLES`, 16: maximum cycles of ownership before forced release; used only with `OUR_ARB_TIMEOUT_EN`; must be ≥ 2.
- `clk`  in  1: sole clock; all logic on the rising edge.
- `rst`  in  1: reset, synchronous and active-high.
- `req`  in  NUM_REQ: level request per requester; held until granted and served.
- `done`  in  1: one-cycle pulse from the resource when the current transaction completes.
- `gnt`  out  NUM_REQ: registered one-hot grant; all zero when nobody owns the resource.
- `gnt_id`  out  $clog2(NUM_REQ): index of the current owner; 0 when `gnt` is zero.
- `start`  out  1: one-cycle pulse in the first cycle of each grant.
- `busy`  out  1: high while a grant is held.
- `timeout_err`  out  1: one-cycle pulse on forced release; constant 0 without the macro.

## Operation
- **FSM states:** IDLE, OWN, GAP.
- **IDLE:**
  - If `req` is non-zero, pick the first set bit searching upward from `ptr`, wrapping modulo NUM_REQ.
  - Register the winner into `gnt`/`gnt_id`, then go to OWN.
  - If `req` is zero, stay in IDLE.
- **OWN:**
  - `busy`=1.
  - `start`=1 in the first OWN cycle only.
  - Release when either occurs: `done`=1, or the owner's `req` bit is 0 (abandon).
  - On release: `ptr` ← owner+1 mod NUM_REQ, `gnt` cleared, go to GAP.
- **GAP:** exactly one cycle with `gnt`=0 and `busy`=0, then IDLE. Requests are not evaluated in GAP.
- **Simultaneous events:** `done` and a `req` drop in the same cycle give a single release.
- **Ignored inputs:** `done` in IDLE or GAP is ignored.
- **Non-owner requests:** changes to `req` bits of non-owners in OWN have no effect.
- **Pointer:** `ptr` has width $clog2(NUM_REQ). Wrap from NUM_REQ-1 to 0 is explicit, so non-power-of-two NUM_REQ is legal.

## Timing
- **Reset values:** `gnt`=0, `gnt_id`=0, `start`=0, `busy`=0, `timeout_err`=0, `ptr`=0, state IDLE.
- **Reset mid-OWN:** takes effect at the next edge. No `timeout_err` is generated.
- **Grant latency:**
  - A `req` sampled at edge t in IDLE drives `gnt` and `start` high after edge t.
  - `start` deasserts after edge t+1.
- **Release:**
  - `done` sampled at edge r clears `gnt`/`busy` after edge r.
  - After edge r+1 the FSM is in IDLE, and `req` is evaluated at edge r+2.
  - Minimum grant-to-grant spacing is therefore 3 cycles.
- **Fairness:** each requester waits at most NUM_REQ-1 grants while continuously requesting.
- **Outputs:** all outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- Macro: `OUR_ARB_TIMEOUT_EN`.
- **Defined:**
  - An ownership counter is cleared on entry to OWN and increments each OWN cycle.
  - When it reaches TIMEOUT_CYCLES with no `done`, the FSM forces release: same `ptr` advance and GAP as a normal release, with `timeout_err` pulsed for one cycle together with the clear of `gnt`.
  - If `done` arrives in the same cycle as the timeout, `done` wins and there is no error.
- **Undefined:** no counter, ownership is unbounded, and `timeout_err` is tied to 0.

## Structure
- Package `our_arb_pkg`:
  - state enum `arb_state_e` (IDLE, OWN, GAP);
  - default constants for NUM_REQ and TIMEOUT_CYCLES;
  - a function returning $clog2-based index width.
- Sub-module `our_rr_pick`: combinational round-robin picker with inputs `req` and `ptr`, outputs one-hot `pick`, `pick_id` and `any`. It is instantiated once inside `our_arbiter`.

## Test plan
- **Reset:**
  - Stimulus: assert `rst` for 2 cycles with `req`=4'b1111.
  - Required: all outputs 0; after release, `gnt`=4'b0001 one cycle later, with `start` pulsed.
- **Rotation:**
  - Stimulus: hold `req`=4'b1111 and pulse `done` 2 cycles after each grant.
  - Required: `gnt_id` sequence 0,1,2,3,0, with exactly one GAP cycle between grants.
- **Wrap and skip:**
  - Stimulus: `ptr`=3 (after serving 2), `req`=4'b0101.
  - Required: grant goes to 0, then to 2.
- **Abandon:**
  - Stimulus: requester 1 owns, then drops `req[1]` with no `done`.
  - Required: `gnt` cleared next cycle, `ptr`=2, `timeout_err`=0.
- **Timeout (macro defined, TIMEOUT_CYCLES=16):**
  - Stimulus: owner never sees `done`.
  - Required: `gnt` clears after the 16th OWN cycle with `timeout_err` pulsed once.
  - Variant: `done` coincident with the 16th cycle gives no error.
- **Mid-transaction reset:**
  - Stimulus: assert `rst` in the 3rd OWN cycle of requester 2.
  - Required: `gnt`=0 and `busy`=0 next cycle, and the next grant goes to requester 0, not 3.
